// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//   Multi-cycle shift unit for the 32-bit datapath. An operation is accepted
//   with a start pulse, then the working value is shifted up to STEP bit
//   positions per clock until the requested amount has been applied. The
//   controlling FSM sees busy while shifting and a one-cycle done pulse when
//   the result appears on data_out.
//
// Ports
//   clk       in   1        system clock, rising edge
//   reset     in   1        synchronous, active-high reset (priority over all)
//   start     in   1        request; accepted in IDLE or DONE, ignored in SHIFT
//   op        in   2        00=SLL 01=SRL 10=SRA 11=ROL
//   shamt     in   SHAMT_W  shift amount 0..WIDTH-1
//   data_in   in   WIDTH    operand
//   busy      out  1        high exactly while in SHIFT
//   done      out  1        one-cycle pulse when data_out is loaded
//   data_out  out  WIDTH    result; held until the next accepted start
// -----------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] rem_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   data_out_q;

    logic [SHAMT_W-1:0] step_n;
    logic [SHAMT_W-1:0] rem_d;
    logic [WIDTH-1:0]   work_d;

    // Shift v by n positions according to op. ROL takes the upper half of a
    // doubled copy shifted left, so bits leaving the MSB re-enter at the LSB.
    function automatic logic [WIDTH-1:0] shift_by(
        input op_e                op_f,
        input logic [WIDTH-1:0]   v,
        input logic [SHAMT_W-1:0] n
    );
        logic [2*WIDTH-1:0] dbl;
        dbl = '0;
        case (op_f)
            OP_SLL:  shift_by = v << n;
            OP_SRL:  shift_by = v >> n;
            OP_SRA:  shift_by = $signed(v) >>> n;
            OP_ROL: begin
                dbl      = {v, v} << n;
                shift_by = dbl[2*WIDTH-1:WIDTH];
            end
            default: shift_by = v;
        endcase
    endfunction

    // NOTE: combinational next-value logic uses blocking assignments with a
    // default for every output first, so no latch can be inferred.
    always_comb begin
        step_n = STEP_C;
        if (rem_q < STEP_C) begin
            step_n = rem_q;
        end
        work_d = shift_by(op_q, work_q, step_n);
        rem_d  = rem_q - step_n;
    end

    // NOTE: all state is updated with non-blocking assignments; reset is
    // sampled on the clock edge and clears every register, including the
    // working value and remaining count, so a discarded shift leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_SLL;
            work_q     <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q <= op_e'(op);
                        if (shamt == '0) begin
                            // Nothing to shift: result is the operand itself.
                            state_q    <= S_DONE;
                            data_out_q <= data_in;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= S_SHIFT;
                            work_q  <= data_in;
                            rem_q   <= shamt;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    // Last step: publish the freshly shifted value directly.
                    if (rem_d == '0) begin
                        state_q    <= S_DONE;
                        data_out_q <= work_d;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule
